// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Decode-to-execute pipeline register sitting directly in front of the ALU.
//   Latches the decoded instruction, resolves both ALU operands against the
//   EX/MEM and MEM/WB writeback buses, and inserts a bubble on a load-use
//   hazard.
//
// Ports
//   i_clk, i_rst            rising-edge clock, async active-high reset
//   i_stall                 hold stage contents (downstream not ready)
//   i_flush                 replace stage contents with a bubble
//   i_id_*                  decoded instruction from the ID stage
//   i_exmem_*, i_memwb_*    destination/enable/value of later stages
//   o_ex_valid              execute slot holds a real instruction
//   o_ex_op_a, o_ex_op_b    forwarded ALU operands
//   o_ex_alu_opsel          ALU operation select
//   o_ex_rd/_rd_we/_is_load destination info passed down the pipe
//   o_fwd_a_sel/_b_sel      0=reg file, 1=EX/MEM, 2=MEM/WB, 3=immediate (b)
//   o_load_use_stall        upstream must hold fetch/decode this cycle
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int REG_WIDTH   = 32,
  parameter int OPSEL_WIDTH = 6,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_id_valid,
  input  logic [OPSEL_WIDTH-1:0] i_id_alu_opsel,
  input  logic [RADDR_WIDTH-1:0] i_id_rs_a,
  input  logic [RADDR_WIDTH-1:0] i_id_rs_b,
  input  logic [REG_WIDTH-1:0]   i_id_rs_a_data,
  input  logic [REG_WIDTH-1:0]   i_id_rs_b_data,
  input  logic [REG_WIDTH-1:0]   i_id_imm,
  input  logic                   i_id_use_imm,
  input  logic [RADDR_WIDTH-1:0] i_id_rd,
  input  logic                   i_id_rd_we,
  input  logic                   i_id_is_load,
  input  logic [RADDR_WIDTH-1:0] i_exmem_rd,
  input  logic [RADDR_WIDTH-1:0] i_memwb_rd,
  input  logic                   i_exmem_we,
  input  logic                   i_memwb_we,
  input  logic [REG_WIDTH-1:0]   i_exmem_result,
  input  logic [REG_WIDTH-1:0]   i_memwb_result,
  output logic                   o_ex_valid,
  output logic [REG_WIDTH-1:0]   o_ex_op_a,
  output logic [REG_WIDTH-1:0]   o_ex_op_b,
  output logic [OPSEL_WIDTH-1:0] o_ex_alu_opsel,
  output logic [RADDR_WIDTH-1:0] o_ex_rd,
  output logic                   o_ex_rd_we,
  output logic                   o_ex_is_load,
  output logic [1:0]             o_fwd_a_sel,
  output logic [1:0]             o_fwd_b_sel,
  output logic                   o_load_use_stall
);

  logic                   r_valid;
  logic [OPSEL_WIDTH-1:0] r_opsel;
  logic [RADDR_WIDTH-1:0] r_rs_a;
  logic [RADDR_WIDTH-1:0] r_rs_b;
  logic [REG_WIDTH-1:0]   r_a_data;
  logic [REG_WIDTH-1:0]   r_b_data;
  logic [REG_WIDTH-1:0]   r_imm;
  logic                   r_use_imm;
  logic [RADDR_WIDTH-1:0] r_rd;
  logic                   r_rd_we;
  logic                   r_is_load;

  logic                   w_load_use;
  logic [1:0]             w_fwd_a_sel;
  logic [1:0]             w_fwd_b_sel;
  logic [REG_WIDTH-1:0]   w_op_a;
  logic [REG_WIDTH-1:0]   w_op_b;

  // A load in EX cannot supply its data until after MEM, so a dependent
  // instruction in ID must wait one cycle. An immediate-form op_b does not
  // read rs_b and therefore cannot create a hazard through it.
  assign w_load_use = r_valid && r_is_load && r_rd_we && (r_rd != '0) && i_id_valid &&
                      ((i_id_rs_a == r_rd) || (!i_id_use_imm && (i_id_rs_b == r_rd)));

  // Bubbles clear every field, not just valid/rd_we, so the ALU sees a
  // clean all-zero operation and no stale index can trigger forwarding.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_opsel   <= '0;
      r_rs_a    <= '0;
      r_rs_b    <= '0;
      r_a_data  <= '0;
      r_b_data  <= '0;
      r_imm     <= '0;
      r_use_imm <= 1'b0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_is_load <= 1'b0;
    end else if (i_flush || (!i_stall && w_load_use)) begin
      r_valid   <= 1'b0;
      r_opsel   <= '0;
      r_rs_a    <= '0;
      r_rs_b    <= '0;
      r_a_data  <= '0;
      r_b_data  <= '0;
      r_imm     <= '0;
      r_use_imm <= 1'b0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_is_load <= 1'b0;
    end else if (!i_stall) begin
      r_valid   <= i_id_valid;
      r_opsel   <= i_id_alu_opsel;
      r_rs_a    <= i_id_rs_a;
      r_rs_b    <= i_id_rs_b;
      r_a_data  <= i_id_rs_a_data;
      r_b_data  <= i_id_rs_b_data;
      r_imm     <= i_id_imm;
      r_use_imm <= i_id_use_imm;
      r_rd      <= i_id_rd;
      r_rd_we   <= i_id_rd_we;
      r_is_load <= i_id_is_load;
    end
  end

  // Forwarding uses the registered source indices, so operands held during
  // a stall keep re-resolving and pick up writebacks that arrive meanwhile.
  // EX/MEM is younger than MEM/WB and so takes priority.
  always_comb begin
    w_fwd_a_sel = 2'd0;
    w_op_a      = r_a_data;
    if (i_exmem_we && (i_exmem_rd != '0) && (i_exmem_rd == r_rs_a)) begin
      w_fwd_a_sel = 2'd1;
      w_op_a      = i_exmem_result;
    end else if (i_memwb_we && (i_memwb_rd != '0) && (i_memwb_rd == r_rs_a)) begin
      w_fwd_a_sel = 2'd2;
      w_op_a      = i_memwb_result;
    end

    w_fwd_b_sel = 2'd0;
    w_op_b      = r_b_data;
    if (r_use_imm) begin
      w_fwd_b_sel = 2'd3;
      w_op_b      = r_imm;
    end else if (i_exmem_we && (i_exmem_rd != '0) && (i_exmem_rd == r_rs_b)) begin
      w_fwd_b_sel = 2'd1;
      w_op_b      = i_exmem_result;
    end else if (i_memwb_we && (i_memwb_rd != '0) && (i_memwb_rd == r_rs_b)) begin
      w_fwd_b_sel = 2'd2;
      w_op_b      = i_memwb_result;
    end
  end

  assign o_ex_valid       = r_valid;
  assign o_ex_op_a        = w_op_a;
  assign o_ex_op_b        = w_op_b;
  assign o_ex_alu_opsel   = r_opsel;
  assign o_ex_rd          = r_rd;
  assign o_ex_rd_we       = r_rd_we;
  assign o_ex_is_load     = r_is_load;
  assign o_fwd_a_sel      = w_fwd_a_sel;
  assign o_fwd_b_sel      = w_fwd_b_sel;
  assign o_load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        id_valid;
  logic [5:0]  id_alu_opsel;
  logic [4:0]  id_rs_a, id_rs_b, id_rd;
  logic [31:0] id_rs_a_data, id_rs_b_data, id_imm;
  logic        id_use_imm, id_rd_we, id_is_load;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_we, memwb_we;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [31:0] ex_op_a, ex_op_b;
  logic [5:0]  ex_alu_opsel;
  logic [4:0]  ex_rd;
  logic        ex_rd_we, ex_is_load;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        load_use_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_id_valid      (id_valid),
    .i_id_alu_opsel  (id_alu_opsel),
    .i_id_rs_a       (id_rs_a),
    .i_id_rs_b       (id_rs_b),
    .i_id_rs_a_data  (id_rs_a_data),
    .i_id_rs_b_data  (id_rs_b_data),
    .i_id_imm        (id_imm),
    .i_id_use_imm    (id_use_imm),
    .i_id_rd         (id_rd),
    .i_id_rd_we      (id_rd_we),
    .i_id_is_load    (id_is_load),
    .i_exmem_rd      (exmem_rd),
    .i_memwb_rd      (memwb_rd),
    .i_exmem_we      (exmem_we),
    .i_memwb_we      (memwb_we),
    .i_exmem_result  (exmem_result),
    .i_memwb_result  (memwb_result),
    .o_ex_valid      (ex_valid),
    .o_ex_op_a       (ex_op_a),
    .o_ex_op_b       (ex_op_b),
    .o_ex_alu_opsel  (ex_alu_opsel),
    .o_ex_rd         (ex_rd),
    .o_ex_rd_we      (ex_rd_we),
    .o_ex_is_load    (ex_is_load),
    .o_fwd_a_sel     (fwd_a_sel),
    .o_fwd_b_sel     (fwd_b_sel),
    .o_load_use_stall(load_use_stall)
  );

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled from here, well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0;
    id_valid = 0; id_alu_opsel = 0; id_rs_a = 0; id_rs_b = 0; id_rd = 0;
    id_rs_a_data = 0; id_rs_b_data = 0; id_imm = 0;
    id_use_imm = 0; id_rd_we = 0; id_is_load = 0;
    exmem_rd = 0; memwb_rd = 0; exmem_we = 0; memwb_we = 0;
    exmem_result = 0; memwb_result = 0;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rb,
                           input logic [31:0] da, input logic [31:0] db, input logic [4:0] rd);
    id_valid = 1; id_alu_opsel = op; id_rs_a = ra; id_rs_b = rb;
    id_rs_a_data = da; id_rs_b_data = db; id_rd = rd; id_rd_we = 1;
    id_use_imm = 0; id_imm = 0; id_is_load = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    repeat (2) tick();
    rst = 0;
    set_instr(6'd12, 5'd1, 5'd2, 32'h1234, 32'h5678, 5'd6);
    tick();
    stall = 1;
    tick();
    #3 rst = 1;
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ex_valid); end
    n_checks++; if (ex_op_a !== 32'h0) begin n_fail++; $display("FAIL rst_op_a: got %h want 0", ex_op_a); end
    n_checks++; if (ex_op_b !== 32'h0) begin n_fail++; $display("FAIL rst_op_b: got %h want 0", ex_op_b); end
    n_checks++; if ({ex_alu_opsel, ex_rd, ex_rd_we, ex_is_load} !== 13'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h/%h/%b/%b want 0", ex_alu_opsel, ex_rd, ex_rd_we, ex_is_load); end
    n_checks++; if ({fwd_a_sel, fwd_b_sel, load_use_stall} !== 5'h0) begin n_fail++; $display("FAIL rst_sel: got %h/%h/%b want 0", fwd_a_sel, fwd_b_sel, load_use_stall); end
    rst = 0; stall = 0;
    set_instr(6'd5, 5'd1, 5'd2, 32'd7, 32'd9, 5'd3);
    tick();
    n_checks++; if (ex_op_a !== 32'd7) begin n_fail++; $display("FAIL post_rst_op_a: got %0d want 7", ex_op_a); end
    n_checks++; if (ex_op_b !== 32'd9) begin n_fail++; $display("FAIL post_rst_op_b: got %0d want 9", ex_op_b); end
    n_checks++; if (ex_valid !== 1'b1 || ex_alu_opsel !== 6'd5 || ex_rd !== 5'd3 || ex_rd_we !== 1'b1) begin n_fail++; $display("FAIL post_rst_ctrl: got v=%b op=%0d rd=%0d we=%b want 1/5/3/1", ex_valid, ex_alu_opsel, ex_rd, ex_rd_we); end
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    set_instr(6'd1, 5'd3, 5'd6, 32'h11, 32'h22, 5'd7);
    tick();
    exmem_rd = 3; exmem_we = 1; exmem_result = 32'hAA;
    memwb_rd = 3; memwb_we = 1; memwb_result = 32'hBB;
    #1;
    n_checks++; if (ex_op_a !== 32'hAA || fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL fwd_exmem_wins: got %h sel %0d want aa sel 1", ex_op_a, fwd_a_sel); end
    n_checks++; if (ex_op_b !== 32'h22 || fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL fwd_b_nomatch: got %h sel %0d want 22 sel 0", ex_op_b, fwd_b_sel); end
    exmem_we = 0;
    #1;
    n_checks++; if (ex_op_a !== 32'hBB || fwd_a_sel !== 2'd2) begin n_fail++; $display("FAIL fwd_memwb: got %h sel %0d want bb sel 2", ex_op_a, fwd_a_sel); end
    memwb_we = 0;
    #1;
    n_checks++; if (ex_op_a !== 32'h11 || fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL fwd_none: got %h sel %0d want 11 sel 0", ex_op_a, fwd_a_sel); end
    exmem_rd = 6; exmem_we = 1; exmem_result = 32'hCC;
    #1;
    n_checks++; if (ex_op_b !== 32'hCC || fwd_b_sel !== 2'd1 || fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL fwd_b_exmem: got %h sel %0d/%0d want cc sel 1/0", ex_op_b, fwd_b_sel, fwd_a_sel); end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    set_instr(6'd2, 5'd0, 5'd0, 32'h0, 32'h0, 5'd1);
    tick();
    exmem_rd = 0; exmem_we = 1; exmem_result = 32'h55;
    memwb_rd = 0; memwb_we = 1; memwb_result = 32'h66;
    #1;
    n_checks++; if (ex_op_a !== 32'h0 || fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL zero_reg_a: got %h sel %0d want 0 sel 0", ex_op_a, fwd_a_sel); end
    n_checks++; if (ex_op_b !== 32'h0 || fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL zero_reg_b: got %h sel %0d want 0 sel 0", ex_op_b, fwd_b_sel); end
  endtask

  task automatic test_immediate();
    clear_inputs();
    set_instr(6'd4, 5'd1, 5'd5, 32'h1, 32'h33, 5'd2);
    id_use_imm = 1; id_imm = 32'h10;
    tick();
    exmem_rd = 5; exmem_we = 1; exmem_result = 32'h77;
    #1;
    n_checks++; if (ex_op_b !== 32'h10 || fwd_b_sel !== 2'd3) begin n_fail++; $display("FAIL imm_b: got %h sel %0d want 10 sel 3", ex_op_b, fwd_b_sel); end
    clear_inputs();
    set_instr(6'd8, 5'd1, 5'd0, 32'h0, 32'h0, 5'd4);
    id_is_load = 1;
    tick();
    set_instr(6'd9, 5'd2, 5'd4, 32'h0, 32'h0, 5'd8);
    id_use_imm = 1;
    #1;
    n_checks++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL imm_no_hazard: got %b want 0", load_use_stall); end
    id_use_imm = 0;
    #1;
    n_checks++; if (load_use_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_rs_b: got %b want 1", load_use_stall); end
  endtask

  // EX still holds the load with rd=4 from test_immediate.
  task automatic test_load_use();
    set_instr(6'd9, 5'd4, 5'd7, 32'h44, 32'h0, 5'd8);
    id_valid = 0;
    #1;
    n_checks++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_id_invalid: got %b want 0", load_use_stall); end
    id_valid = 1;
    #1;
    n_checks++; if (load_use_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_rs_a: got %b want 1", load_use_stall); end
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_rd_we !== 1'b0 || ex_alu_opsel !== 6'd0 || ex_is_load !== 1'b0) begin n_fail++; $display("FAIL hazard_bubble: got v=%b we=%b op=%0d ld=%b want 0/0/0/0", ex_valid, ex_rd_we, ex_alu_opsel, ex_is_load); end
    n_checks++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_clears: got %b want 0", load_use_stall); end
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_alu_opsel !== 6'd9 || ex_rd !== 5'd8 || ex_op_a !== 32'h44) begin n_fail++; $display("FAIL hazard_replay: got v=%b op=%0d rd=%0d a=%h want 1/9/8/44", ex_valid, ex_alu_opsel, ex_rd, ex_op_a); end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    set_instr(6'd3, 5'd1, 5'd2, 32'h10, 32'h20, 5'd5);
    tick();
    stall = 1; flush = 1;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_rd_we !== 1'b0 || ex_alu_opsel !== 6'd0) begin n_fail++; $display("FAIL flush_over_stall: got v=%b we=%b op=%0d want 0/0/0", ex_valid, ex_rd_we, ex_alu_opsel); end
    stall = 0; flush = 0;
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_alu_opsel !== 6'd3) begin n_fail++; $display("FAIL reload: got v=%b op=%0d want 1/3", ex_valid, ex_alu_opsel); end
    stall = 1;
    set_instr(6'h3F, 5'd9, 5'd10, 32'hDEAD, 32'hBEEF, 5'd11);
    tick();
    n_checks++; if (ex_alu_opsel !== 6'd3 || ex_op_b !== 32'h20 || ex_valid !== 1'b1 || ex_rd !== 5'd5) begin n_fail++; $display("FAIL stall_hold1: got op=%0d b=%h v=%b rd=%0d want 3/20/1/5", ex_alu_opsel, ex_op_b, ex_valid, ex_rd); end
    tick();
    memwb_rd = 2; memwb_we = 1; memwb_result = 32'h99;
    #1;
    n_checks++; if (ex_op_b !== 32'h99 || fwd_b_sel !== 2'd2) begin n_fail++; $display("FAIL stall_fwd_live: got %h sel %0d want 99 sel 2", ex_op_b, fwd_b_sel); end
    tick();
    n_checks++; if (ex_alu_opsel !== 6'd3 || ex_op_a !== 32'h10 || ex_op_b !== 32'h99) begin n_fail++; $display("FAIL stall_hold3: got op=%0d a=%h b=%h want 3/10/99", ex_alu_opsel, ex_op_a, ex_op_b); end
    stall = 0; memwb_we = 0;
    tick();
    n_checks++; if (ex_alu_opsel !== 6'h3F || ex_op_a !== 32'hDEAD || ex_rd !== 5'd11) begin n_fail++; $display("FAIL stall_release: got op=%h a=%h rd=%0d want 3f/dead/11", ex_alu_opsel, ex_op_a, ex_rd); end
    flush = 1;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_rd_we !== 1'b0) begin n_fail++; $display("FAIL flush_alone: got v=%b we=%b want 0/0", ex_valid, ex_rd_we); end
    flush = 0;
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    for (int i = 1; i <= 3; i++) begin
      set_instr(6'(i), 5'(i + 10), 5'(i + 20), 32'(i * 16), 32'(i * 256), 5'(i));
      tick();
      n_checks++;
      if (ex_valid !== 1'b1 || ex_alu_opsel !== 6'(i) || ex_op_a !== 32'(i * 16) ||
          ex_op_b !== 32'(i * 256) || ex_rd !== 5'(i)) begin
        n_fail++;
        $display("FAIL b2b_%0d: got v=%b op=%0d a=%h b=%h rd=%0d want 1/%0d/%h/%h/%0d",
                 i, ex_valid, ex_alu_opsel, ex_op_a, ex_op_b, ex_rd, i, i * 16, i * 256, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_zero_reg();
    test_immediate();
    test_load_use();
    test_stall_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline register with operand forwarding and load-use detection. It sits directly upstream of the ALU in the pipeline. It latches the decoded instruction and drives op_a, op_b and alu_opsel into the ALU. Operands are resolved against the EX/MEM and MEM/WB writeback buses, and a bubble is inserted automatically on a load-use hazard.

Parameters:
REG_WIDTH, 32, data/operand width (matches ALU operand width)
OPSEL_WIDTH, 6, ALU operation-select width
RADDR_WIDTH, 5, register index width; index 0 is the hard-wired zero register

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
stall  in  1  hold stage contents (downstream not ready)
flush  in  1  replace next stage contents with a bubble (branch/exception)
id_valid  in  1  decode slot holds a real instruction
id_alu_opsel  in  OPSEL_WIDTH  decoded ALU operation
id_rs_a, id_rs_b  in  RADDR_WIDTH  source register indices
id_rs_a_data, id_rs_b_data  in  REG_WIDTH  register-file read data
id_imm  in  REG_WIDTH  sign/zero-extended immediate
id_use_imm  in  1  op_b takes id_imm instead of rs_b
id_rd  in  RADDR_WIDTH  destination index
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a memory load
exmem_rd, memwb_rd  in  RADDR_WIDTH  destination indices of later stages
exmem_we, memwb_we  in  1  later stage will write its rd
exmem_result, memwb_result  in  REG_WIDTH  values being written
ex_valid  out  1  execute slot valid
ex_op_a, ex_op_b  out  REG_WIDTH  forwarded ALU operands
ex_alu_opsel  out  OPSEL_WIDTH  to ALU
ex_rd, ex_rd_we, ex_is_load  out  RADDR_WIDTH/1/1  passed down the pipe
fwd_a_sel, fwd_b_sel  out  2  forwarding source select: 0=reg, 1=EX/MEM, 2=MEM/WB, 3=immediate (b only)
load_use_stall  out  1  upstream must hold fetch/decode this cycle

Behaviour:
- Reset: asynchronous, active-high. All registered state clears to 0: ex_valid=0, opsel=0, rd=0, rd_we=0, is_load=0, stored operands/imm=0. Outputs are therefore ex_op_a=ex_op_b=0 and fwd_*_sel=0.
- Stored per stage: valid, opsel, rs_a, rs_b, a_data, b_data, imm, use_imm, rd, rd_we, is_load.
- Per-edge priority (highest first):
  - rst: clear all state.
  - flush: load a bubble (valid=0, rd_we=0, is_load=0, opsel=0).
  - stall: hold every register unchanged.
  - load_use_stall: load a bubble; the upstream decode slot is held by the upstream stage.
  - Otherwise: load id_* inputs.
- Bubble: ALU still sees opsel 0. Because rd_we=0, the bubble has no architectural effect.
- load_use_stall (combinational): ex_valid & ex_is_load & ex_rd_we & ex_rd!=0 & id_valid & (id_rs_a==ex_rd | (!id_use_imm & id_rs_b==ex_rd)).
- Forwarding (combinational, computed from registered rs indices):
  - Operand A: if exmem_we & exmem_rd!=0 & exmem_rd==rs_a, sel=1, use exmem_result.
  - Else if memwb_we & memwb_rd!=0 & memwb_rd==rs_a, sel=2, use memwb_result.
  - Else sel=0, use a_data.
  - Operand B: same rules, except use_imm=1 forces sel=3 and imm, with no forwarding applied.
  - EX/MEM always wins over MEM/WB when both match.
- Forwarding stays live during stall. Held operands re-resolve every cycle, so a writeback that arrives while stalled is picked up.
- Latency: one cycle from id_* to ex_*. There is no back-to-back bubble unless a hazard or flush occurs.
- Reset mid-stall or mid-flush: reset wins immediately (asynchronous). load_use_stall goes to 0 with ex_valid.

Test Plan:
- Reset with stall=1 held: assert rst mid-cycle -> all outputs 0 before the next edge; after release, id_valid=1, opsel=5, rs data 7/9 loads -> ex_op_a=7, ex_op_b=9, ex_valid=1 one cycle later.
- Forward priority: rs_a=3, exmem_rd=3/we=1/result=0xAA, memwb_rd=3/we=1/result=0xBB -> ex_op_a=0xAA, fwd_a_sel=1. Then drop exmem_we -> ex_op_a=0xBB, fwd_a_sel=2.
- Zero register: rs_a=0, exmem_rd=0, exmem_we=1, result=0x55, a_data=0 -> ex_op_a=0, fwd_a_sel=0.
- Immediate: use_imm=1, imm=0x10, rs_b matches exmem_rd -> ex_op_b=0x10, fwd_b_sel=3. Also, load in EX with rd=4 and id rs_b=4, use_imm=1 -> load_use_stall=0.
- Load-use: EX holds a load with rd=4, ID reads rs_a=4 -> load_use_stall=1. Next edge gives ex_valid=0, ex_rd_we=0. The following edge, with the ID instruction re-presented, gives ex_valid=1.
- Stall vs flush: stall=1 and flush=1 together -> bubble loaded. Stall=1 alone for 3 cycles -> outputs held, while a memwb write to rs_b in cycle 2 updates ex_op_b.
